// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
// Optional statistics counters are enabled by defining FIFO_WR_ARBITER_STATS_EN.
package fifo_arb_pkg;

    // Arbiter FSM states
    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_t;

    // Width of every statistics counter
    localparam int STAT_W = 16;

    // Number of bits needed to hold values 0..max_value (at least 1)
    function automatic int width_for(input int max_value);
        return (max_value < 2) ? 1 : $clog2(max_value + 1);
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Combinational round-robin picker: finds the first valid requester
// strictly after last_grant_i, wrapping modulo NUM_REQ.
module rr_picker
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = width_for(NUM_REQ - 1)
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [IDX_W-1:0]   last_grant_i,
    output logic [NUM_REQ-1:0] pick_onehot_o,
    output logic [IDX_W-1:0]   pick_idx_o,
    output logic               any_valid_o
);

    // One extra bit so last_grant + offset (at most 2*NUM_REQ-1) never overflows
    logic [IDX_W:0] w_cand;
    logic           w_found;

    // Scan candidates in priority order and keep the first valid one
    always_comb begin
        pick_onehot_o = {NUM_REQ{1'b0}};
        pick_idx_o    = {IDX_W{1'b0}};
        w_found       = 1'b0;
        w_cand        = {(IDX_W+1){1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            w_cand = {1'b0, last_grant_i} + (IDX_W+1)'(i + 1);
            if (w_cand >= (IDX_W+1)'(NUM_REQ)) begin
                w_cand = w_cand - (IDX_W+1)'(NUM_REQ);
            end else begin
                w_cand = w_cand;
            end
            if (!w_found && valid_i[w_cand[IDX_W-1:0]]) begin
                pick_onehot_o[w_cand[IDX_W-1:0]] = 1'b1;
                pick_idx_o                       = w_cand[IDX_W-1:0];
                w_found                          = 1'b1;
            end else begin
                w_found = w_found;
            end
        end
        any_valid_o = |valid_i;
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the FIFO write port between NUM_REQ packet
// streams. A grant is held for a whole packet or MAX_BURST accepted beats,
// followed by one idle cycle before the next arbitration.
// Define FIFO_WR_ARBITER_STATS_EN to add per-requester beat counters and a
// back-pressure stall counter.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DSIZE     = 8,
    parameter int MAX_BURST = 64
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    input  logic [NUM_REQ-1:0]       req_last_i,
    input  logic [NUM_REQ*DSIZE-1:0] req_data_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    input  logic                     fifo_full_i,
    output logic                     fifo_wr_en_o,
    output logic [DSIZE-1:0]         fifo_wr_data_o,
    output logic [NUM_REQ-1:0]       grant_o,
    output logic                     busy_o
`ifdef FIFO_WR_ARBITER_STATS_EN
    ,
    output logic [NUM_REQ*STAT_W-1:0] stat_beats_o,
    output logic [STAT_W-1:0]         stat_stall_o
`endif
);

    localparam int                IDX_W     = width_for(NUM_REQ - 1);
    localparam int                CNT_W     = width_for(MAX_BURST);
    localparam logic [CNT_W-1:0]  BURST_END = CNT_W'(MAX_BURST - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_REQ - 1);

    arb_state_t         r_state;
    logic [NUM_REQ-1:0] r_grant;
    logic [IDX_W-1:0]   r_last_grant;
    logic [CNT_W-1:0]   r_beat_cnt;

    logic [NUM_REQ-1:0] w_pick_onehot;
    logic [IDX_W-1:0]   w_pick_idx;
    logic               w_any_valid;
    logic               w_busy;
    logic               w_g_valid;
    logic               w_g_last;
    logic               w_accept;
    logic               w_burst_done;
    logic [DSIZE-1:0]   w_data;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .valid_i       (req_valid_i),
        .last_grant_i  (r_last_grant),
        .pick_onehot_o (w_pick_onehot),
        .pick_idx_o    (w_pick_idx),
        .any_valid_o   (w_any_valid)
    );

    // Granted requester's handshake and data, selected by the registered one-hot grant
    always_comb begin
        w_busy    = (r_state == ARB_BURST);
        w_g_valid = |(req_valid_i & r_grant);
        w_g_last  = |(req_last_i & r_grant);
        w_data    = {DSIZE{1'b0}};
        for (int k = 0; k < NUM_REQ; k++) begin
            if (r_grant[k]) begin
                w_data = w_data | req_data_i[k*DSIZE +: DSIZE];
            end else begin
                w_data = w_data;
            end
        end
        // A beat is only ever written while the FIFO reports space
        w_accept     = w_busy & w_g_valid & ~fifo_full_i;
        w_burst_done = w_accept & (w_g_last | (r_beat_cnt == BURST_END));
    end

    // Port-facing handshake outputs
    always_comb begin
        if (w_busy && !fifo_full_i) begin
            req_ready_o = r_grant;
        end else begin
            req_ready_o = {NUM_REQ{1'b0}};
        end
        fifo_wr_en_o   = w_accept;
        fifo_wr_data_o = w_data;
        grant_o        = r_grant;
        busy_o         = w_busy;
    end

    // Arbitration FSM: pick in IDLE, hold grant through the packet or burst limit
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state      <= ARB_IDLE;
            r_grant      <= {NUM_REQ{1'b0}};
            r_last_grant <= IDX_LAST;
            r_beat_cnt   <= {CNT_W{1'b0}};
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_any_valid) begin
                        r_state      <= ARB_BURST;
                        r_grant      <= w_pick_onehot;
                        r_last_grant <= w_pick_idx;
                        r_beat_cnt   <= {CNT_W{1'b0}};
                    end
                end
                ARB_BURST: begin
                    if (w_accept) begin
                        r_beat_cnt <= r_beat_cnt + CNT_W'(1);
                    end
                    if (w_burst_done) begin
                        r_state <= ARB_IDLE;
                        r_grant <= {NUM_REQ{1'b0}};
                    end
                end
                default: begin
                    r_state      <= ARB_IDLE;
                    r_grant      <= {NUM_REQ{1'b0}};
                    r_last_grant <= IDX_LAST;
                    r_beat_cnt   <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

`ifdef FIFO_WR_ARBITER_STATS_EN
    logic [NUM_REQ*STAT_W-1:0] r_stat_beats;
    logic [STAT_W-1:0]         r_stat_stall;

    // Wrapping per-requester beat counters and saturating full-stall counter
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_stat_beats <= {(NUM_REQ*STAT_W){1'b0}};
            r_stat_stall <= {STAT_W{1'b0}};
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (w_accept && r_grant[k]) begin
                    r_stat_beats[k*STAT_W +: STAT_W] <= r_stat_beats[k*STAT_W +: STAT_W] + STAT_W'(1);
                end
            end
            if (w_busy && w_g_valid && fifo_full_i && (r_stat_stall != {STAT_W{1'b1}})) begin
                r_stat_stall <= r_stat_stall + STAT_W'(1);
            end
        end
    end

    assign stat_beats_o = r_stat_beats;
    assign stat_stall_o = r_stat_stall;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: a cycle-level behavioural model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_fifo_wr_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int DSIZE     = 8;
    localparam int MAX_BURST = 4;

    logic                     clk = 1'b0;
    logic                     reset_i;
    logic [NUM_REQ-1:0]       req_valid_i;
    logic [NUM_REQ-1:0]       req_last_i;
    logic [NUM_REQ*DSIZE-1:0] req_data_i;
    logic [NUM_REQ-1:0]       req_ready_o;
    logic                     fifo_full_i;
    logic                     fifo_wr_en_o;
    logic [DSIZE-1:0]         fifo_wr_data_o;
    logic [NUM_REQ-1:0]       grant_o;
    logic                     busy_o;
`ifdef FIFO_WR_ARBITER_STATS_EN
    logic [NUM_REQ*16-1:0]    stat_beats_o;
    logic [15:0]              stat_stall_o;
`endif

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .DSIZE     (DSIZE),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk_i          (clk),
        .reset_i        (reset_i),
        .req_valid_i    (req_valid_i),
        .req_last_i     (req_last_i),
        .req_data_i     (req_data_i),
        .req_ready_o    (req_ready_o),
        .fifo_full_i    (fifo_full_i),
        .fifo_wr_en_o   (fifo_wr_en_o),
        .fifo_wr_data_o (fifo_wr_data_o),
        .grant_o        (grant_o),
        .busy_o         (busy_o)
`ifdef FIFO_WR_ARBITER_STATS_EN
        ,
        .stat_beats_o   (stat_beats_o),
        .stat_stall_o   (stat_stall_o)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int onehot_idx(input logic [NUM_REQ-1:0] v);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (v[i]) return i;
        end
        return 15;
    endfunction

    // Per-requester pending beats: {last, data}
    logic [8:0]  q [NUM_REQ][$];
    bit          rand_valid = 1'b0;
    // Observed FIFO writes: {requester index, data}
    logic [11:0] wlog [$];
    int          obs_stall = 0;

    // Behavioural model state
    bit m_on = 1'b0;
    bit m_busy;
    int m_g;
    int m_last;
    int m_cnt;
    int m_beats [NUM_REQ];
    int m_stall;

    // Compare DUT against model, log writes, then advance the model past the next edge
    always @(negedge clk) begin : cmp
        logic [NUM_REQ-1:0] e_grant;
        logic [NUM_REQ-1:0] e_ready;
        logic               e_wr;
        logic [7:0]         e_data;
        int                 gi;
        int                 c;
        if (m_on) begin
            e_grant = '0;
            if (m_busy) e_grant[m_g] = 1'b1;
            e_ready = (m_busy && !fifo_full_i) ? e_grant : '0;
            e_wr    = m_busy && req_valid_i[m_g] && !fifo_full_i;
            e_data  = m_busy ? req_data_i[m_g*8 +: 8] : 8'h00;
            check("grant_o", grant_o, e_grant);
            check("busy_o", busy_o, m_busy);
            check("req_ready_o", req_ready_o, e_ready);
            check("fifo_wr_en_o", fifo_wr_en_o, e_wr);
            check("fifo_wr_data_o", fifo_wr_data_o, e_data);
`ifdef FIFO_WR_ARBITER_STATS_EN
            for (int k = 0; k < NUM_REQ; k++) begin
                check("stat_beats_o", stat_beats_o[k*16 +: 16], 16'(m_beats[k]));
            end
            check("stat_stall_o", stat_stall_o, 16'(m_stall));
`endif
        end
        if (fifo_wr_en_o) begin
            gi = onehot_idx(grant_o);
            wlog.push_back({gi[3:0], fifo_wr_data_o});
        end
        if (busy_o && |(req_valid_i & grant_o) && fifo_full_i) obs_stall++;
        if (reset_i) begin
            m_on   = 1'b1;
            m_busy = 1'b0;
            m_last = NUM_REQ - 1;
            m_cnt  = 0;
            m_stall = 0;
            for (int k = 0; k < NUM_REQ; k++) m_beats[k] = 0;
        end else if (m_on) begin
            if (!m_busy) begin
                for (int k = 1; k <= NUM_REQ; k++) begin
                    c = (m_last + k) % NUM_REQ;
                    if (!m_busy && req_valid_i[c]) begin
                        m_busy = 1'b1;
                        m_g    = c;
                        m_last = c;
                        m_cnt  = 0;
                    end
                end
            end else if (req_valid_i[m_g] && !fifo_full_i) begin
                m_cnt++;
                m_beats[m_g] = (m_beats[m_g] + 1) % 65536;
                if (req_last_i[m_g] || m_cnt == MAX_BURST) m_busy = 1'b0;
            end else if (req_valid_i[m_g] && fifo_full_i && m_stall < 65535) begin
                m_stall++;
            end
        end
    end

    task automatic drive_inputs();
        for (int k = 0; k < NUM_REQ; k++) begin
            if (q[k].size() > 0 && (!rand_valid || $urandom_range(0, 3) != 0)) begin
                req_valid_i[k]          = 1'b1;
                req_last_i[k]           = q[k][0][8];
                req_data_i[k*8 +: 8]    = q[k][0][7:0];
            end else begin
                req_valid_i[k]          = 1'b0;
                req_last_i[k]           = 1'($urandom_range(0, 1));
                req_data_i[k*8 +: 8]    = 8'($urandom_range(0, 255));
            end
        end
    endtask

    // One clock: note handshakes, pass the edge, retire accepted beats, present new inputs
    task automatic cycle();
        logic [NUM_REQ-1:0] acc;
        @(negedge clk);
        acc = req_valid_i & req_ready_o;
        @(posedge clk);
        #1;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (acc[k] && q[k].size() > 0) void'(q[k].pop_front());
        end
        drive_inputs();
        #1;
    endtask

    task automatic push_pkt(input int k, input int base, input int len);
        for (int i = 0; i < len; i++) begin
            q[k].push_back({(i == len - 1) ? 1'b1 : 1'b0, 8'(base + i)});
        end
    endtask

    function automatic bit any_pending();
        for (int k = 0; k < NUM_REQ; k++) begin
            if (q[k].size() > 0) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic reset_dut();
        reset_i     = 1'b1;
        fifo_full_i = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) q[k].delete();
        drive_inputs();
        cycle();
        cycle();
        reset_i = 1'b0;
        cycle();
    endtask

    task automatic run_drain(input int budget);
        int n = 0;
        while (any_pending() && n < budget) begin
            cycle();
            n++;
        end
        check("drain_pending", any_pending(), 1'b0);
        cycle();
        cycle();
    endtask

    task automatic wait_wlog(input int n, input int budget);
        int t = 0;
        while (wlog.size() < n && t < budget) begin
            cycle();
            t++;
        end
        check("wlog_wait", (wlog.size() >= n), 1'b1);
    endtask

    task automatic check_wlog(input string name, input logic [11:0] exp[$]);
        check({name, "_count"}, wlog.size(), exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            check(name, (i < wlog.size()) ? wlog[i] : 12'hfff, exp[i]);
        end
    endtask

    initial begin
        logic [11:0] exp_q [$];
        reset_i     = 1'b1;
        fifo_full_i = 1'b0;
        req_valid_i = '0;
        req_last_i  = '0;
        req_data_i  = '0;

        // Reset values
        reset_dut();
        check("rst_grant", grant_o, 4'b0000);
        check("rst_busy", busy_o, 1'b0);
        check("rst_ready", req_ready_o, 4'b0000);
        check("rst_wr_en", fifo_wr_en_o, 1'b0);
        check("rst_data", fifo_wr_data_o, 8'h00);

        // Single requester, 3-beat packet
        q[1].push_back({1'b0, 8'h11});
        q[1].push_back({1'b0, 8'h22});
        q[1].push_back({1'b1, 8'h33});
        drive_inputs();
        #1;
        check("t1_pre_grant", grant_o, 4'b0000);
        check("t1_pre_wr", fifo_wr_en_o, 1'b0);
        cycle();
        check("t1_grant", grant_o, 4'b0010);
        check("t1_ready", req_ready_o, 4'b0010);
        check("t1_wr0", fifo_wr_en_o, 1'b1);
        check("t1_d0", fifo_wr_data_o, 8'h11);
        cycle();
        check("t1_wr1", fifo_wr_en_o, 1'b1);
        check("t1_d1", fifo_wr_data_o, 8'h22);
        cycle();
        check("t1_wr2", fifo_wr_en_o, 1'b1);
        check("t1_d2", fifo_wr_data_o, 8'h33);
        cycle();
        check("t1_end_grant", grant_o, 4'b0000);
        check("t1_end_busy", busy_o, 1'b0);
        check("t1_end_wr", fifo_wr_en_o, 1'b0);

        // Round-robin, 2-beat packets, requester 0 has two packets
        reset_dut();
        wlog.delete();
        push_pkt(0, 8'h00, 2);
        push_pkt(0, 8'h02, 2);
        push_pkt(1, 8'h10, 2);
        push_pkt(2, 8'h20, 2);
        push_pkt(3, 8'h30, 2);
        drive_inputs();
        #1;
        run_drain(100);
        exp_q = '{12'h000, 12'h001, 12'h110, 12'h111, 12'h220, 12'h221,
                  12'h330, 12'h331, 12'h002, 12'h003};
        check_wlog("rr_order", exp_q);
`ifdef FIFO_WR_ARBITER_STATS_EN
        check("rr_stat_beats", stat_beats_o, {16'd2, 16'd2, 16'd2, 16'd4});
`endif

        // Back-pressure: full for 5 cycles after two beats of requester 2
        wlog.delete();
        obs_stall = 0;
        push_pkt(2, 8'hA0, 4);
        drive_inputs();
        #1;
        wait_wlog(2, 20);
        fifo_full_i = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            check("bp_wr_en", fifo_wr_en_o, 1'b0);
            check("bp_ready2", req_ready_o[2], 1'b0);
            cycle();
        end
        fifo_full_i = 1'b0;
        run_drain(50);
        exp_q = '{12'h2A0, 12'h2A1, 12'h2A2, 12'h2A3};
        check_wlog("bp_data", exp_q);
        check("bp_stall_cycles", obs_stall, 5);
        check("bp_model_stall", m_stall, 5);
`ifdef FIFO_WR_ARBITER_STATS_EN
        check("bp_stat_stall", stat_stall_o, 16'd5);
`endif

        // Forced split at MAX_BURST=4 with requester 3 waiting
        reset_dut();
        wlog.delete();
        push_pkt(0, 8'h00, 6);
        push_pkt(3, 8'h30, 2);
        drive_inputs();
        #1;
        run_drain(100);
        exp_q = '{12'h000, 12'h001, 12'h002, 12'h003, 12'h330, 12'h331,
                  12'h004, 12'h005};
        check_wlog("split", exp_q);

        // Reset in the middle of a 5-beat burst
        reset_dut();
        wlog.delete();
        push_pkt(0, 8'h50, 5);
        drive_inputs();
        #1;
        wait_wlog(2, 20);
        reset_i = 1'b1;
        cycle();
        check("mr_grant", grant_o, 4'b0000);
        check("mr_busy", busy_o, 1'b0);
        check("mr_wr_en", fifo_wr_en_o, 1'b0);
        reset_i = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) q[k].delete();
        push_pkt(1, 8'h61, 1);
        push_pkt(0, 8'h60, 1);
        drive_inputs();
        #1;
        cycle();
        check("mr_prio_grant", grant_o, 4'b0001);
        run_drain(50);

        // Randomized traffic with random valid gaps, back-pressure and one reset
        reset_dut();
        rand_valid = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (q[k].size() < 8 && $urandom_range(0, 7) == 0) begin
                    push_pkt(k, int'($urandom_range(0, 255)), int'($urandom_range(1, 9)));
                end
            end
            fifo_full_i = ($urandom_range(0, 3) == 0);
            reset_i     = (n == 1500);
            cycle();
        end
        fifo_full_i = 1'b0;
        reset_i     = 1'b0;
        rand_valid  = 1'b0;
        run_drain(2000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time bound
    initial begin
        #2000000;
        $display("FAIL watchdog expired at %0t", $time);
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

endmodule
